cacheline_burst_adaptor: RTL and testbench

Converts the cache datapath's single-cycle 256-bit line transfers (`pmem_address`/`pmem_wdata`/`pmem_rdata`) into four 64-bit bursts on the physical memory bus. Sits directly downstream of the cache datapath and controller, between them and main memory. Holds one outstanding line transfer, read or write, and signals completion with a single-cycle response.

---
 rtl/cacheline_burst_adaptor_pkg.sv | 13 +
 rtl/cacheline_burst_adaptor.sv | 93 +++++++++
 tb/tb_cacheline_burst_adaptor.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared cache-side types and constants used by the line/burst adaptor.
package pkg_cache;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } adaptor_state_t;

   localparam int unsigned BURST_BEATS = 4;

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Converts single-cycle cache line transfers into BURST_BEATS memory beats,
// holding one outstanding read or write and pulsing resp_o on completion.
module cacheline_burst_adaptor
   import pkg_cache::*;
#(
   parameter int unsigned s_offset = 5,
   parameter int unsigned s_burst  = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [8*(2**s_offset)-1:0]     line_i,
   output logic [8*(2**s_offset)-1:0]     line_o,
   input  logic [31:0]                    address_i,
   input  logic                           read_i,
   input  logic                           write_i,
   output logic                           resp_o,
   input  logic [s_burst-1:0]             burst_i,
   output logic [s_burst-1:0]             burst_o,
   output logic [31:0]                    address_o,
   output logic                           read_o,
   output logic                           write_o,
   input  logic                           resp_i
);

   localparam int unsigned         CntW     = $clog2(BURST_BEATS);
   localparam logic [CntW-1:0]     LastBeat = CntW'(BURST_BEATS - 1);
   localparam logic [31:0]         AddrMask = ~((32'd1 << s_offset) - 32'd1);

   adaptor_state_t                          state_q, state_d;
   logic [CntW-1:0]                         cnt_q, cnt_d;
   logic [31:0]                             addr_q, addr_d;
   // One buffer holds either the line being assembled or the line being sent.
   logic [BURST_BEATS-1:0][s_burst-1:0]     buf_q, buf_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      buf_d   = buf_q;
      unique case (state_q)
         IDLE: begin
            // Read takes priority when the cache raises both requests.
            if (read_i) begin
               addr_d  = address_i & AddrMask;
               cnt_d   = '0;
               state_d = READ;
            end else if (write_i) begin
               addr_d  = address_i & AddrMask;
               buf_d   = line_i;
               cnt_d   = '0;
               state_d = WRITE;
            end
         end
         READ: begin
            if (resp_i) begin
               buf_d[cnt_q] = burst_i;
               cnt_d        = cnt_q + CntW'(1);
               if (cnt_q == LastBeat) state_d = DONE;
            end
         end
         WRITE: begin
            if (resp_i) begin
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == LastBeat) state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign read_o    = (state_q == READ);
   assign write_o   = (state_q == WRITE);
   assign resp_o    = (state_q == DONE);
   assign address_o = addr_q;
   assign line_o    = buf_q;
   assign burst_o   = (state_q == WRITE) ? buf_q[cnt_q] : '0;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed cycle-exact bench for cacheline_burst_adaptor.
module tb_cacheline_burst_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] line_i, line_o;
   logic [31:0]  address_i, address_o;
   logic         read_i, write_i, resp_o, read_o, write_o, resp_i;
   logic [63:0]  burst_i, burst_o;

   int vectors     = 0;
   int miscompares = 0;

   localparam logic [63:0] W0 = 64'h0123456789ABCDEF;
   localparam logic [63:0] W1 = 64'h1122334455667788;
   localparam logic [63:0] W2 = 64'hF0E1D2C3B4A59687;
   localparam logic [63:0] W3 = 64'hFEDCBA9876543210;
   localparam logic [255:0] WLINE = {W3, W2, W1, W0};

   always #5 clk = ~clk;

   cacheline_burst_adaptor #(
      .s_offset(5),
      .s_burst (64)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .line_i   (line_i),
      .line_o   (line_o),
      .address_i(address_i),
      .read_i   (read_i),
      .write_i  (write_i),
      .resp_o   (resp_o),
      .burst_i  (burst_i),
      .burst_o  (burst_o),
      .address_o(address_o),
      .read_o   (read_o),
      .write_o  (write_o),
      .resp_i   (resp_i)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      line_i = '0; address_i = '0; burst_i = '0;
      #1 rst = 1'b1;
      #2;
      vectors++;
      if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h0 || burst_o !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got r/w/resp=%b%b%b addr=%h burst=%h expected 000/0/0",
                  read_o, write_o, resp_o, address_o, burst_o);
      end
      vectors++;
      if (line_o !== 256'h0) begin
         miscompares++;
         $display("FAIL reset_line: got %h expected 0", line_o);
      end
      tick; tick;
      rst = 1'b0;
      tick;
      // Beats strobed while idle must not disturb anything
      resp_i = 1'b1; burst_i = '1;
      tick; tick;
      resp_i = 1'b0;
      vectors++;
      if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== 256'h0) begin
         miscompares++;
         $display("FAIL idle_resp_ignored: got r/w/resp=%b%b%b line=%h expected 000 line 0",
                  read_o, write_o, resp_o, line_o);
      end
   endtask

   task automatic test_read_contig;
      logic [63:0]  b [4];
      logic [255:0] exp_line;
      b = '{64'h1111111111111111, 64'h2222222222222222,
            64'h3333333333333333, 64'h4444444444444444};
      exp_line = {b[3], b[2], b[1], b[0]};
      address_i = 32'h12345678; read_i = 1'b1;
      tick;
      vectors++;
      if (address_o !== 32'h12345660) begin
         miscompares++;
         $display("FAIL read_addr: got %h expected 12345660", address_o);
      end
      address_i = 32'hFFFFFFFF;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (read_o !== 1'b1 || resp_o !== 1'b0 || write_o !== 1'b0) begin
            miscompares++;
            $display("FAIL read_beat%0d_ctrl: got r/w/resp=%b%b%b expected 100", k, read_o, write_o, resp_o);
         end
         resp_i = 1'b1; burst_i = b[k];
         tick;
      end
      burst_i = '1;
      vectors++;
      if (resp_o !== 1'b1 || read_o !== 1'b0) begin
         miscompares++;
         $display("FAIL read_done: got resp=%b read=%b expected resp=1 read=0", resp_o, read_o);
      end
      vectors++;
      if (line_o !== exp_line || address_o !== 32'h12345660) begin
         miscompares++;
         $display("FAIL read_line: got %h addr %h expected %h addr 12345660", line_o, address_o, exp_line);
      end
      tick;
      read_i = 1'b0; resp_i = 1'b0;
      vectors++;
      if (resp_o !== 1'b0 || line_o !== exp_line) begin
         miscompares++;
         $display("FAIL read_after_done: got resp=%b line=%h expected resp=0 line %h", resp_o, line_o, exp_line);
      end
   endtask

   task automatic test_write;
      logic [63:0] w [4];
      w = '{W0, W1, W2, W3};
      address_i = 32'h0000_2044; line_i = WLINE; write_i = 1'b1;
      tick;
      line_i = '0;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (write_o !== 1'b1 || read_o !== 1'b0 || resp_o !== 1'b0 || burst_o !== w[k]) begin
            miscompares++;
            $display("FAIL write_beat%0d: got w/r/resp=%b%b%b burst=%h expected 100 burst=%h",
                     k, write_o, read_o, resp_o, burst_o, w[k]);
         end
         resp_i = 1'b1;
         tick;
      end
      resp_i = 1'b0;
      vectors++;
      if (write_o !== 1'b0 || resp_o !== 1'b1 || address_o !== 32'h0000_2040 || burst_o !== 64'h0) begin
         miscompares++;
         $display("FAIL write_done: got write=%b resp=%b addr=%h burst=%h expected 0 1 00002040 0",
                  write_o, resp_o, address_o, burst_o);
      end
      tick;
      write_i = 1'b0;
   endtask

   task automatic test_stall;
      int          pat [7];
      logic [63:0] sb [4];
      int          n;
      pat = '{1, 0, 0, 1, 1, 0, 1};
      sb  = '{64'hA0A0A0A0A0A0A0A0, 64'hB1B1B1B1B1B1B1B1,
              64'hC2C2C2C2C2C2C2C2, 64'hD3D3D3D3D3D3D3D3};
      n = 0;
      address_i = 32'h0000ABFF; read_i = 1'b1;
      tick;
      for (int c = 0; c < 7; c++) begin
         vectors++;
         if (read_o !== 1'b1 || resp_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_cyc%0d: got read=%b resp=%b expected read=1 resp=0", c + 1, read_o, resp_o);
         end
         resp_i = (pat[c] != 0);
         burst_i = (pat[c] != 0) ? sb[n] : 64'hDEADBEEFDEADBEEF;
         if (pat[c] != 0) n++;
         tick;
      end
      resp_i = 1'b0;
      vectors++;
      if (resp_o !== 1'b1 || read_o !== 1'b0 || address_o !== 32'h0000ABE0) begin
         miscompares++;
         $display("FAIL stall_done: got resp=%b read=%b addr=%h expected 1 0 0000abe0", resp_o, read_o, address_o);
      end
      vectors++;
      if (line_o !== {sb[3], sb[2], sb[1], sb[0]}) begin
         miscompares++;
         $display("FAIL stall_line: got %h expected %h", line_o, {sb[3], sb[2], sb[1], sb[0]});
      end
      tick;
      read_i = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [63:0] rb [4];
      rb = '{64'h5555555555555555, 64'h6666666666666666,
             64'h7777777777777777, 64'h8888888888888888};
      address_i = 32'h80000040; read_i = 1'b1;
      tick;
      for (int k = 0; k < 2; k++) begin
         resp_i = 1'b1; burst_i = rb[k];
         tick;
      end
      resp_i = 1'b0;
      rst = 1'b1;
      #1;
      vectors++;
      if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h0 || line_o !== 256'h0) begin
         miscompares++;
         $display("FAIL midreset_outputs: got r/w/resp=%b%b%b addr=%h line=%h expected all 0",
                  read_o, write_o, resp_o, address_o, line_o);
      end
      read_i = 1'b0;
      tick;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         vectors++;
         if (resp_o !== 1'b0 || read_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_quiet%0d: got resp=%b read=%b expected 0 0", c, resp_o, read_o);
         end
         tick;
      end
      address_i = 32'h80000040; read_i = 1'b1;
      tick;
      for (int k = 0; k < 4; k++) begin
         resp_i = 1'b1; burst_i = rb[k];
         tick;
      end
      resp_i = 1'b0;
      vectors++;
      if (resp_o !== 1'b1 || line_o !== {rb[3], rb[2], rb[1], rb[0]} || address_o !== 32'h80000040) begin
         miscompares++;
         $display("FAIL midreset_reread: got resp=%b addr=%h line=%h expected 1 80000040 %h",
                  resp_o, address_o, line_o, {rb[3], rb[2], rb[1], rb[0]});
      end
      tick;
      read_i = 1'b0;
   endtask

   task automatic test_both;
      logic [63:0] qb [4];
      qb = '{64'h0000000000000001, 64'h0000000000000002,
             64'h0000000000000003, 64'h0000000000000004};
      address_i = 32'h00001000; line_i = WLINE; read_i = 1'b1; write_i = 1'b1;
      tick;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (read_o !== 1'b1 || write_o !== 1'b0 || burst_o !== 64'h0) begin
            miscompares++;
            $display("FAIL both_beat%0d: got read=%b write=%b burst=%h expected 1 0 0", k, read_o, write_o, burst_o);
         end
         resp_i = 1'b1; burst_i = qb[k];
         tick;
      end
      resp_i = 1'b0;
      vectors++;
      if (resp_o !== 1'b1 || line_o !== {qb[3], qb[2], qb[1], qb[0]}) begin
         miscompares++;
         $display("FAIL both_done: got resp=%b line=%h expected 1 %h", resp_o, line_o, {qb[3], qb[2], qb[1], qb[0]});
      end
      tick;
      read_i = 1'b0; write_i = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [63:0] nb [4];
      nb = '{64'h9999999999999999, 64'hAAAAAAAAAAAAAAAA,
             64'hBBBBBBBBBBBBBBBB, 64'hCCCCCCCCCCCCCCCC};
      address_i = 32'h20000020; line_i = WLINE; write_i = 1'b1;
      tick;
      for (int k = 0; k < 4; k++) begin
         resp_i = 1'b1;
         tick;
      end
      resp_i = 1'b0;
      vectors++;
      if (resp_o !== 1'b1 || write_o !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_write_done: got resp=%b write=%b expected 1 0", resp_o, write_o);
      end
      tick;
      write_i = 1'b0; read_i = 1'b1; address_i = 32'h30000000;
      vectors++;
      if (read_o !== 1'b0 || resp_o !== 1'b0 || line_o !== WLINE) begin
         miscompares++;
         $display("FAIL b2b_gap: got read=%b resp=%b line=%h expected 0 0 %h", read_o, resp_o, line_o, WLINE);
      end
      tick;
      // Shared buffer: the line stays put until the read's first beat lands
      vectors++;
      if (read_o !== 1'b1 || address_o !== 32'h30000000 || line_o !== WLINE) begin
         miscompares++;
         $display("FAIL b2b_read_start: got read=%b addr=%h line=%h expected 1 30000000 %h",
                  read_o, address_o, line_o, WLINE);
      end
      resp_i = 1'b1; burst_i = nb[0];
      tick;
      vectors++;
      if (line_o !== {W3, W2, W1, nb[0]}) begin
         miscompares++;
         $display("FAIL b2b_first_beat: got %h expected %h", line_o, {W3, W2, W1, nb[0]});
      end
      for (int k = 1; k < 4; k++) begin
         resp_i = 1'b1; burst_i = nb[k];
         tick;
      end
      resp_i = 1'b0;
      vectors++;
      if (resp_o !== 1'b1 || line_o !== {nb[3], nb[2], nb[1], nb[0]}) begin
         miscompares++;
         $display("FAIL b2b_read_done: got resp=%b line=%h expected 1 %h", resp_o, line_o, {nb[3], nb[2], nb[1], nb[0]});
      end
      tick;
      read_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset;
      test_read_contig;
      test_write;
      test_stall;
      test_reset_mid;
      test_both;
      test_back_to_back;
      tick;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
